rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/m72_pkg.sv | 21 ++
 rtl/rom_addr_map.sv | 16 +
 rtl/rom_loader.sv | 171 +++++++++++++++++
 tb/tb_rom_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/m72_pkg.sv
// m72_pkg: board types, ROM region map and loader state encoding shared by the M72 ROM loader.
package m72_pkg;
  typedef enum logic [7:0] {
    M72_RTYPE    = 8'h00,
    M72_GALLOP   = 8'h01,
    M72_XMULTIPL = 8'h02,
    M72_DBREED   = 8'h03
  } board_type_t;
  typedef struct packed {
    logic [24:0] base_addr;
    logic        reorder_64;
  } region_t;
  localparam region_t LOAD_REGIONS [4] = '{
    '{25'h000000, 1'b0},
    '{25'h100000, 1'b1},
    '{25'h200000, 1'b0},
    '{25'h300000, 1'b0}
  };
  localparam logic [31:0] MAX_REGION_LEN = 32'h100000;
  typedef enum logic [2:0] {IDLE, BOARD, HDR, DATA, WRITE, DONE, ERR} load_state_t;
endpackage

// File: rtl/rom_addr_map.sv
// rom_addr_map: registered SDRAM byte address of a byte pair, linear or 64-bit quarter-interleaved.
module rom_addr_map
  import m72_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  region_t     region,
  input  logic [20:0] o_within,
  input  logic [1:0]  quarter,
  output logic [24:0] addr
);
  always_ff @(posedge clk or posedge reset)
    if (reset) addr <= '0;
    else addr <= region.base_addr + (region.reorder_64 ?
                 25'({o_within[20:1], 3'b000}) + 25'({quarter, 1'b0}) : 25'(o_within));
endmodule

// File: rtl/rom_loader.sv
// rom_loader: parses a board-type byte plus four length-prefixed ROM regions and writes them to SDRAM as 16-bit words.
module rom_loader
  import m72_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        download,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        sdr_req,
  input  logic        sdr_ack,
  output logic [24:0] sdr_addr,
  output logic [15:0] sdr_data,
  output logic [1:0]  sdr_be,
  output board_type_t board_type,
  output logic        load_done,
  output logic        load_error
);
  load_state_t state;
  logic        dl_q, phase, restart_pend, abort_pend;
  logic [1:0]  region, hcnt, q, pair_q;
  logic [23:0] len;
  logic [20:0] rem, w, qm1, pair_w;
  logic [7:0]  pair_lo;
  logic [24:0] map_addr;
  logic        rise, fall, acc, first, w_last, last_region, rs, ab;
  logic [31:0] nlen;
  region_t     rgn;

  assign rise        = download & ~dl_q;
  assign fall        = ~download & dl_q;
  assign in_ready    = !(state inside {IDLE, WRITE});
  assign acc         = in_valid & in_ready;
  assign first       = state == DATA && acc && !phase;
  assign nlen        = {len, in_data};
  assign rgn         = LOAD_REGIONS[region];
  assign w_last      = rgn.reorder_64 && w == qm1;
  assign last_region = region == 2'd3;
  assign rs          = rise | (restart_pend & ~fall);
  assign ab          = fall | (abort_pend & ~rise);

  // The map sees the live counters while the first byte of a pair is taken so odd tails are ready on time.
  rom_addr_map u_map (
    .clk(clk), .reset(reset), .region(rgn),
    .o_within(first ? w : pair_w), .quarter(first ? q : pair_q), .addr(map_addr)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      dl_q <= 1'b0;
      phase <= 1'b0;
      restart_pend <= 1'b0;
      abort_pend <= 1'b0;
      region <= '0;
      hcnt <= '0;
      q <= '0;
      pair_q <= '0;
      len <= '0;
      rem <= '0;
      w <= '0;
      qm1 <= '0;
      pair_w <= '0;
      pair_lo <= '0;
      sdr_req <= 1'b0;
      sdr_addr <= '0;
      sdr_data <= '0;
      sdr_be <= '0;
      board_type <= M72_RTYPE;
      load_done <= 1'b0;
      load_error <= 1'b0;
    end else begin
      dl_q <= download;
      if ((rise || restart_pend) && state != WRITE) begin
        state <= BOARD;
        region <= '0;
        hcnt <= '0;
        phase <= 1'b0;
        load_done <= 1'b0;
        load_error <= 1'b0;
        restart_pend <= 1'b0;
        abort_pend <= 1'b0;
      end else if (fall && !(state inside {IDLE, DONE, WRITE})) begin
        state <= IDLE;
        load_error <= 1'b1;
      end else case (state)
        BOARD: if (acc) begin
          board_type <= board_type_t'(in_data);
          hcnt <= '0;
          state <= HDR;
        end
        HDR: if (acc) begin
          len <= nlen[23:0];
          hcnt <= hcnt + 2'd1;
          if (hcnt == 2'd3) begin
            if (nlen > MAX_REGION_LEN || (rgn.reorder_64 && nlen[1:0] != 2'b00)) begin
              state <= ERR;
              load_error <= 1'b1;
            end else if (nlen == 32'd0) begin
              if (last_region) begin
                state <= DONE;
                load_done <= 1'b1;
              end else region <= region + 2'd1;
            end else begin
              rem <= nlen[20:0];
              w <= '0;
              q <= '0;
              qm1 <= nlen[22:2] - 21'd1;
              phase <= 1'b0;
              state <= DATA;
            end
          end
        end
        DATA: if (acc) begin
          rem <= rem - 21'd1;
          w <= w_last ? '0 : w + 21'd1;
          q <= q + {1'b0, w_last};
          if (!phase) begin
            pair_lo <= in_data;
            pair_w <= w;
            pair_q <= q;
            if (rem == 21'd1) begin
              sdr_data <= {8'h00, in_data};
              sdr_be <= 2'b01;
              state <= WRITE;
            end else phase <= 1'b1;
          end else begin
            sdr_data <= {in_data, pair_lo};
            sdr_be <= 2'b11;
            phase <= 1'b0;
            state <= WRITE;
          end
        end
        WRITE: begin
          if (rise) begin
            restart_pend <= 1'b1;
            abort_pend <= 1'b0;
          end else if (fall) begin
            abort_pend <= 1'b1;
            restart_pend <= 1'b0;
          end
          if (!sdr_req) begin
            sdr_req <= 1'b1;
            sdr_addr <= map_addr;
          end else if (sdr_ack) begin
            sdr_req <= 1'b0;
            if (rs) begin
              state <= IDLE;
              restart_pend <= 1'b1;
              abort_pend <= 1'b0;
            end else if (ab) begin
              state <= IDLE;
              load_error <= 1'b1;
              abort_pend <= 1'b0;
            end else if (rem == 21'd0) begin
              if (last_region) begin
                state <= DONE;
                load_done <= 1'b1;
              end else begin
                region <= region + 2'd1;
                hcnt <= '0;
                state <= HDR;
              end
            end else state <= DATA;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: table-driven ROM stream scenarios with an SDRAM ack responder and hand-written corner sequences.
module tb_rom_loader;
  import m72_pkg::*;

  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } wr_t;
  typedef struct packed {
    logic [7:0]       board;
    logic [3:0][31:0] len;
    logic [7:0]       first, nexp, dly;
    logic             done, err;
    logic [7:0]       bexp;
  } sc_t;

  logic clk, reset, download, in_valid, in_ready, sdr_req, sdr_ack, load_done, load_error;
  logic [7:0] in_data;
  logic [24:0] sdr_addr;
  logic [15:0] sdr_data;
  logic [1:0] sdr_be;
  board_type_t board_type;

  int checks = 0, errors = 0, ack_delay = 0;
  logic stall_chk = 1'b0;
  wr_t got[$];
  wr_t exp_wr [32];
  sc_t sc [6];
  logic [7:0] stream[$];

  rom_loader dut (
    .clk(clk), .reset(reset), .download(download), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sdr_req(sdr_req), .sdr_ack(sdr_ack), .sdr_addr(sdr_addr),
    .sdr_data(sdr_data), .sdr_be(sdr_be), .board_type(board_type),
    .load_done(load_done), .load_error(load_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got_v, exp_v);
    end
  endtask

  // SDRAM side: log each request, optionally stall, then pulse ack once.
  initial begin
    wr_t cw;
    sdr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (sdr_req === 1'b1) begin
        cw = '{sdr_addr, sdr_data, sdr_be};
        got.push_back(cw);
        for (int k = 0; k < ack_delay; k++) begin
          if (stall_chk) begin
            chk("stall_req", 64'(sdr_req), 64'd1);
            chk("stall_fields", 64'({sdr_addr, sdr_data, sdr_be}), 64'(cw));
            chk("stall_in_ready", 64'(in_ready), 64'd0);
          end
          @(negedge clk);
        end
        sdr_ack = 1'b1;
        @(negedge clk);
        sdr_ack = 1'b0;
      end
    end
  end

  task automatic set_sc(input int i, input logic [7:0] b, input logic [31:0] l0, l1, l2, l3,
                        input int f, n, d, input logic dn, er, input logic [7:0] be);
    sc[i] = '{b, {l3, l2, l1, l0}, 8'(f), 8'(n), 8'(d), dn, er, be};
  endtask

  task automatic ew(input int i, input logic [24:0] a, input logic [15:0] d, input logic [1:0] be);
    exp_wr[i] = '{a, d, be};
  endtask

  task automatic build(input int i);
    stream.delete();
    stream.push_back(sc[i].board);
    for (int r = 0; r < 4; r++) begin
      logic [31:0] l = sc[i].len[r];
      int nd = (l > 32'd64) ? 16 : int'(l);
      for (int b = 3; b >= 0; b--) stream.push_back(l[8*b +: 8]);
      for (int k = 0; k < nd; k++) stream.push_back(8'(k));
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_n(input int cnt);
    for (int k = 0; k < cnt && k < stream.size(); k++) send(stream[k]);
  endtask

  task automatic start(input int i, input int dly, input logic stall);
    ack_delay = dly;
    stall_chk = stall;
    download = 1'b0;
    @(negedge clk);
    got.delete();
    download = 1'b1;
    @(negedge clk);
    build(i);
  endtask

  task automatic run(input int i);
    sc_t s = sc[i];
    int n = 0;
    start(i, int'(s.dly), s.dly != 8'd0);
    send_n(stream.size());
    while (!(load_done || load_error) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk($sformatf("s%0d_load_done", i), 64'(load_done), 64'(s.done));
    chk($sformatf("s%0d_load_error", i), 64'(load_error), 64'(s.err));
    chk($sformatf("s%0d_board_type", i), 64'(board_type), 64'(s.bexp));
    chk($sformatf("s%0d_write_count", i), 64'(got.size()), 64'(s.nexp));
    for (int k = 0; k < int'(s.nexp); k++)
      chk($sformatf("s%0d_write%0d", i, k), (k < got.size()) ? 64'(got[k]) : {64{1'bx}},
          64'(exp_wr[int'(s.first) + k]));
  endtask

  initial begin
    int n;
    // Writes for four 4-byte regions; region 1 has Q=1 so the second pair lands at +4.
    ew(0, 25'h000000, 16'h0100, 2'b11); ew(1, 25'h000002, 16'h0302, 2'b11);
    ew(2, 25'h100000, 16'h0100, 2'b11); ew(3, 25'h100004, 16'h0302, 2'b11);
    ew(4, 25'h200000, 16'h0100, 2'b11); ew(5, 25'h200002, 16'h0302, 2'b11);
    ew(6, 25'h300000, 16'h0100, 2'b11); ew(7, 25'h300002, 16'h0302, 2'b11);
    // Region 1, L=16, Q=4.
    ew(8,  25'h100000, 16'h0100, 2'b11); ew(9,  25'h100008, 16'h0302, 2'b11);
    ew(10, 25'h100002, 16'h0504, 2'b11); ew(11, 25'h10000A, 16'h0706, 2'b11);
    ew(12, 25'h100004, 16'h0908, 2'b11); ew(13, 25'h10000C, 16'h0B0A, 2'b11);
    ew(14, 25'h100006, 16'h0D0C, 2'b11); ew(15, 25'h10000E, 16'h0F0E, 2'b11);
    // Region 0 odd length, region 1 L=8 (Q=2), region 2 empty, region 3 L=2.
    ew(16, 25'h000000, 16'h0100, 2'b11); ew(17, 25'h000002, 16'h0002, 2'b01);
    ew(18, 25'h100000, 16'h0100, 2'b11); ew(19, 25'h100002, 16'h0302, 2'b11);
    ew(20, 25'h100004, 16'h0504, 2'b11); ew(21, 25'h100006, 16'h0706, 2'b11);
    ew(22, 25'h300000, 16'h0100, 2'b11);
    ew(23, 25'h000000, 16'h0100, 2'b11);
    set_sc(0, 8'h01, 4, 4, 4, 4, 0, 8, 0, 1'b1, 1'b0, M72_GALLOP);
    set_sc(1, 8'h00, 0, 16, 0, 0, 8, 8, 0, 1'b1, 1'b0, M72_RTYPE);
    set_sc(2, 8'h02, 3, 8, 0, 2, 16, 7, 0, 1'b1, 1'b0, M72_XMULTIPL);
    set_sc(3, 8'h03, 2, 32'h100001, 4, 4, 23, 1, 0, 1'b0, 1'b1, M72_DBREED);
    set_sc(4, 8'h03, 0, 6, 4, 4, 0, 0, 0, 1'b0, 1'b1, M72_DBREED);
    set_sc(5, 8'h01, 4, 4, 4, 4, 0, 8, 10, 1'b1, 1'b0, M72_GALLOP);

    reset = 1'b1;
    download = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_sdr_req", 64'(sdr_req), 64'd0);
    chk("rst_sdr_addr", 64'(sdr_addr), 64'd0);
    chk("rst_sdr_data", 64'(sdr_data), 64'd0);
    chk("rst_sdr_be", 64'(sdr_be), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_load_done", 64'(load_done), 64'd0);
    chk("rst_load_error", 64'(load_error), 64'd0);
    chk("rst_board_type", 64'(board_type), 64'(M72_RTYPE));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run(i);

    // Download drops after five data bytes, then the full stream is replayed.
    start(0, 0, 1'b0);
    send_n(14);
    download = 1'b0;
    repeat (6) @(negedge clk);
    chk("drop_load_error", 64'(load_error), 64'd1);
    chk("drop_in_ready", 64'(in_ready), 64'd0);
    chk("drop_load_done", 64'(load_done), 64'd0);
    chk("drop_write_count", 64'(got.size()), 64'd2);
    run(0);

    // Reset in the middle of a stalled write drops the request at once.
    start(0, 20, 1'b0);
    send_n(7);
    n = 0;
    while (!sdr_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("midwrite_req_seen", 64'(sdr_req), 64'd1);
    reset = 1'b1;
    #1;
    chk("midwrite_rst_req", 64'(sdr_req), 64'd0);
    chk("midwrite_rst_in_ready", 64'(in_ready), 64'd0);
    chk("midwrite_rst_board", 64'(board_type), 64'(M72_RTYPE));
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    download = 1'b0;
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
